// File: rtl/boid_pkg.sv
// rtl/boid_pkg.sv - shared constants and FSM encoding for the boid frame writer
package boid_pkg;

   localparam int VIDEO_WIDTH  = 640;
   localparam int VIDEO_HEIGHT = 480;
   localparam int PIXEL_COUNT  = VIDEO_WIDTH * VIDEO_HEIGHT;
   localparam int ADDR_W       = 19;
   localparam int MAX_BOIDS    = 4;
   // dx/dy counters only ever need to reach BOID_SIZE-1, and BOID_SIZE <= 4
   localparam int D_W          = 2;

   function automatic int bits_for(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int BITS_FOR_BOIDS = bits_for(MAX_BOIDS);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LATCH,
      ST_DRAW,
      ST_DONE
   } state_t;

endpackage

// File: rtl/boid_pixel_addr.sv
// rtl/boid_pixel_addr.sv - combinational pixel address and visibility for one square slot
module boid_pixel_addr
   import boid_pkg::*;
#(
   parameter int X_W          = 10,
   parameter int Y_W          = 9,
   parameter int VIDEO_WIDTH  = 640,
   parameter int VIDEO_HEIGHT = 480,
   parameter int ADDR_W       = 19
) (
   input  logic [X_W-1:0]    x,
   input  logic [Y_W-1:0]    y,
   input  logic [D_W-1:0]    dx,
   input  logic [D_W-1:0]    dy,
   output logic [ADDR_W-1:0] addr,
   output logic              on_screen
);

   localparam logic [X_W:0] W_LIM = (X_W+1)'(VIDEO_WIDTH);
   localparam logic [Y_W:0] H_LIM = (Y_W+1)'(VIDEO_HEIGHT);

   logic [X_W:0] px;
   logic [Y_W:0] py;

   // one extra bit so a square hanging off the right/bottom edge is detected, not wrapped
   assign px = {1'b0, x} + (X_W+1)'(dx);
   assign py = {1'b0, y} + (Y_W+1)'(dy);

   assign on_screen = (px < W_LIM) && (py < H_LIM);

   // constant multiplier: reduces to shift-add (640 = 512 + 128)
   assign addr = ADDR_W'(py) * ADDR_W'(VIDEO_WIDTH) + ADDR_W'(px);

endmodule

// File: rtl/boid_frame_writer.sv
// rtl/boid_frame_writer.sv - per-frame sequencer drawing every boid as a square into display RAM
module boid_frame_writer
   import boid_pkg::*;
#(
   parameter int MAX_BOIDS    = 4,
   parameter int X_W          = 10,
   parameter int Y_W          = 9,
   parameter int VIDEO_WIDTH  = 640,
   parameter int VIDEO_HEIGHT = 480,
   parameter int ADDR_W       = 19,
   parameter int BOID_SIZE    = 2
) (
   input  logic                           clock,
   input  logic                           resetn,
   input  logic                           frame_start,
   input  logic [X_W-1:0]                 boid_x,
   input  logic [Y_W-1:0]                 boid_y,
   output logic [bits_for(MAX_BOIDS)-1:0] boid_sel,
   output logic                           clr_req,
   output logic                           wr_en,
   output logic [ADDR_W-1:0]              wr_addr,
   output logic                           busy,
   output logic                           frame_done,
   output logic [7:0]                     overrun_cnt
);

   localparam int SEL_W = bits_for(MAX_BOIDS);
   localparam logic [D_W-1:0]   LAST_D   = D_W'(BOID_SIZE - 1);
   localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(MAX_BOIDS - 1);

   state_t            state, state_n;
   logic [SEL_W-1:0]  sel_n;
   logic [X_W-1:0]    x_lat, x_n;
   logic [Y_W-1:0]    y_lat, y_n;
   logic [D_W-1:0]    dx, dx_n, dy, dy_n;
   logic              wr_en_n;
   logic [ADDR_W-1:0] wr_addr_n;
   logic [7:0]        ovr_n;
   logic [ADDR_W-1:0] pix_addr;
   logic              pix_on;

   boid_pixel_addr #(
      .X_W          (X_W),
      .Y_W          (Y_W),
      .VIDEO_WIDTH  (VIDEO_WIDTH),
      .VIDEO_HEIGHT (VIDEO_HEIGHT),
      .ADDR_W       (ADDR_W)
   ) u_pixel_addr (
      .x         (x_lat),
      .y         (y_lat),
      .dx        (dx),
      .dy        (dy),
      .addr      (pix_addr),
      .on_screen (pix_on)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state       <= ST_IDLE;
         boid_sel    <= '0;
         x_lat       <= '0;
         y_lat       <= '0;
         dx          <= '0;
         dy          <= '0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         overrun_cnt <= 8'd0;
      end else begin
         state       <= state_n;
         boid_sel    <= sel_n;
         x_lat       <= x_n;
         y_lat       <= y_n;
         dx          <= dx_n;
         dy          <= dy_n;
         wr_en       <= wr_en_n;
         wr_addr     <= wr_addr_n;
         overrun_cnt <= ovr_n;
      end
   end

   always_comb begin
      state_n   = state;
      sel_n     = boid_sel;
      x_n       = x_lat;
      y_n       = y_lat;
      dx_n      = dx;
      dy_n      = dy;
      wr_en_n   = 1'b0;
      wr_addr_n = '0;
      ovr_n     = overrun_cnt;

      // a start pulse outside IDLE is dropped and only counted
      if (frame_start && (state != ST_IDLE) && (overrun_cnt != 8'hFF))
         ovr_n = overrun_cnt + 8'd1;

      case (state)
         ST_IDLE: begin
            if (frame_start) begin
               state_n = ST_CLEAR;
               sel_n   = '0;
            end
         end
         ST_CLEAR: state_n = ST_LATCH;
         ST_LATCH: begin
            x_n     = boid_x;
            y_n     = boid_y;
            dx_n    = '0;
            dy_n    = '0;
            state_n = ST_DRAW;
         end
         ST_DRAW: begin
            wr_en_n   = pix_on;
            wr_addr_n = pix_on ? pix_addr : '0;
            if (dx == LAST_D) begin
               dx_n = '0;
               if (dy == LAST_D) begin
                  if (boid_sel == LAST_SEL) begin
                     state_n = ST_DONE;
                  end else begin
                     sel_n   = boid_sel + 1'b1;
                     state_n = ST_LATCH;
                  end
               end else begin
                  dy_n = dy + 1'b1;
               end
            end else begin
               dx_n = dx + 1'b1;
            end
         end
         ST_DONE: begin
            sel_n   = '0;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
   end

   assign busy       = (state != ST_IDLE);
   assign clr_req    = (state == ST_CLEAR);
   assign frame_done = (state == ST_DONE);

endmodule

// File: tb/tb_boid_frame_writer.sv
// tb/tb_boid_frame_writer.sv - self-checking bench for boid_frame_writer
module tb_boid_frame_writer;

   localparam int N  = 4;
   localparam int S  = 2;
   localparam int BP = 1 + S * S;
   localparam int F  = 2 + N * BP;
   localparam int PX [4] = '{10, 0, 639, 100};
   localparam int PY [4] = '{5, 0, 479, 200};
   localparam int EXP_W [13] = '{3210, 3211, 3850, 3851, 0, 1, 640, 641,
                                 307199, 128100, 128101, 128740, 128741};

   logic        clock;
   logic        resetn;
   logic        frame_start;
   logic [9:0]  boid_x;
   logic [8:0]  boid_y;
   logic [1:0]  boid_sel;
   logic        clr_req, wr_en, busy, frame_done;
   logic [18:0] wr_addr;
   logic [7:0]  overrun_cnt;

   logic        fs_b, clr_b, wr_en_b, busy_b, done_b;
   logic [0:0]  sel_b;
   logic [18:0] addr_b;
   logic [7:0]  ovr_b;

   logic        fs_c, clr_c, wr_en_c, busy_c, done_c;
   logic [2:0]  sel_c;
   logic [9:0]  bx_c;
   logic [8:0]  by_c;
   logic [18:0] addr_c;
   logic [7:0]  ovr_c;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int t0 = 0;
   bit rec = 0;
   int wq[$];
   int qb[$];
   int nc = 0;

   assign boid_x = 10'(PX[boid_sel]);
   assign boid_y = 9'(PY[boid_sel]);
   assign bx_c   = 10'(sel_c) * 10'd20;
   assign by_c   = 9'(sel_c) * 9'd10;

   boid_frame_writer dut (
      .clock(clock), .resetn(resetn), .frame_start(frame_start),
      .boid_x(boid_x), .boid_y(boid_y), .boid_sel(boid_sel),
      .clr_req(clr_req), .wr_en(wr_en), .wr_addr(wr_addr), .busy(busy),
      .frame_done(frame_done), .overrun_cnt(overrun_cnt)
   );

   boid_frame_writer #(.MAX_BOIDS(1), .BOID_SIZE(1)) dut_b (
      .clock(clock), .resetn(resetn), .frame_start(fs_b),
      .boid_x(10'd3), .boid_y(9'd2), .boid_sel(sel_b),
      .clr_req(clr_b), .wr_en(wr_en_b), .wr_addr(addr_b), .busy(busy_b),
      .frame_done(done_b), .overrun_cnt(ovr_b)
   );

   boid_frame_writer #(.MAX_BOIDS(8), .BOID_SIZE(3)) dut_c (
      .clock(clock), .resetn(resetn), .frame_start(fs_c),
      .boid_x(bx_c), .boid_y(by_c), .boid_sel(sel_c),
      .clr_req(clr_c), .wr_en(wr_en_c), .wr_addr(addr_c), .busy(busy_c),
      .frame_done(done_c), .overrun_cnt(ovr_c)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // expected outputs at phase p cycles after an accepted start (0 = idle)
   task automatic model_at(input int p, output int e_busy, output int e_clr,
                           output int e_done, output int e_sel,
                           output int e_wr, output int e_addr);
      int k, r, j, x, y;
      e_busy = (p >= 1) ? 1 : 0;
      e_clr  = (p == 1) ? 1 : 0;
      e_done = (p == F) ? 1 : 0;
      e_sel  = 0;
      if (p >= 2) begin
         e_sel = (p - 2) / BP;
         if (e_sel > N - 1) e_sel = N - 1;
      end
      e_wr   = 0;
      e_addr = 0;
      if (p >= 3 && p <= F) begin
         k = (p - 3) / BP;
         r = (p - 3) % BP;
         if (r >= 1) begin
            j = r - 1;
            x = PX[k] + j % S;
            y = PY[k] + j / S;
            if (x < 640 && y < 480) begin
               e_wr   = 1;
               e_addr = y * 640 + x;
            end
         end
      end
   endtask

   initial begin : compare
      int mp, movr;
      int e_busy, e_clr, e_done, e_sel, e_wr, e_addr;
      mp = 0;
      movr = 0;
      forever begin
         @(negedge clock);
         if (!resetn) begin
            mp = 0;
            movr = 0;
         end
         model_at(mp, e_busy, e_clr, e_done, e_sel, e_wr, e_addr);
         chk("busy", busy, e_busy);
         chk("clr_req", clr_req, e_clr);
         chk("frame_done", frame_done, e_done);
         chk("boid_sel", boid_sel, e_sel);
         chk("wr_en", wr_en, e_wr);
         if (e_wr == 1) chk("wr_addr", wr_addr, e_addr);
         chk("overrun_cnt", overrun_cnt, movr);
         if (resetn) begin
            if (mp >= 1) begin
               if (frame_start && movr < 255) movr++;
               mp = (mp == F) ? 0 : mp + 1;
            end else if (frame_start) begin
               mp = 1;
            end
         end
      end
   end

   initial begin : monitor
      forever begin
         @(negedge clock);
         if (rec && wr_en) wq.push_back(int'(wr_addr));
         if (wr_en_b) qb.push_back(int'(addr_b));
         if (wr_en_c) nc++;
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic run_to(input int k);
      for (int i = 0; i < 200 && cyc < t0 + k; i++) tick();
   endtask

   task automatic pulse_start();
      frame_start = 1'b1;
      t0 = cyc;
      tick();
      frame_start = 1'b0;
   endtask

   task automatic wait_done(output int off);
      off = -1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (frame_done) begin
            off = cyc - t0;
            return;
         end
      end
   endtask

   task automatic chk_writes(input string name);
      chk({name, "_count"}, wq.size(), 13);
      for (int i = 0; i < 13; i++)
         if (i < wq.size()) chk({name, "_addr"}, wq[i], EXP_W[i]);
   endtask

   initial begin : stim
      int off, ovr_before;
      resetn = 1'b0;
      frame_start = 1'b0;
      fs_b = 1'b0;
      fs_c = 1'b0;
      repeat (5) tick();
      chk("rst_wr_en", wr_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_clr", clr_req, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_sel", boid_sel, 0);
      chk("rst_ovr", overrun_cnt, 0);
      resetn = 1'b1;
      repeat (100) tick();

      // default frame
      rec = 1;
      pulse_start();
      chk("clr_at_1", clr_req, 1);
      wait_done(off);
      chk("done_at_22", off, 22);
      tick();
      chk_writes("frame");
      wq.delete();

      // overrun pulses at +5 and +21
      pulse_start();
      run_to(5);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      run_to(21);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      wait_done(off);
      chk("ovr_done_at_22", off, 22);
      tick();
      ovr_before = int'(overrun_cnt);
      // back-to-back: start on the first IDLE cycle after DONE
      frame_start = 1'b1;
      t0 = cyc;
      chk_writes("ovr_frame");
      chk("ovr_cnt_2", ovr_before, 2);
      wq.delete();
      tick();
      frame_start = 1'b0;
      chk("b2b_clr", clr_req, 1);
      wait_done(off);
      chk("b2b_done_at_22", off, 22);
      tick();
      chk("b2b_ovr", overrun_cnt, 2);
      chk_writes("b2b_frame");
      rec = 0;
      wq.delete();

      // saturation
      frame_start = 1'b1;
      repeat (400) tick();
      frame_start = 1'b0;
      for (int i = 0; i < 40 && busy; i++) tick();
      chk("ovr_sat", overrun_cnt, 255);

      // reset during DRAW of boid 1
      pulse_start();
      run_to(9);
      chk("pre_rst_wr", wr_en, 1);
      chk("pre_rst_sel", boid_sel, 1);
      resetn = 1'b0;
      #1;
      chk("mid_rst_wr", wr_en, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_sel", boid_sel, 0);
      chk("mid_rst_ovr", overrun_cnt, 0);
      tick();
      tick();
      resetn = 1'b1;
      tick();
      rec = 1;
      pulse_start();
      chk("restart_clr", clr_req, 1);
      chk("restart_sel", boid_sel, 0);
      wait_done(off);
      chk("restart_done", off, 22);
      tick();
      chk_writes("restart");
      rec = 0;

      // parameter sweep: 1 boid, size 1
      qb.delete();
      fs_b = 1'b1;
      t0 = cyc;
      tick();
      fs_b = 1'b0;
      off = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (done_b) begin
            off = cyc - t0;
            break;
         end
      end
      chk("b_done_at_4", off, 4);
      tick();
      chk("b_write_count", qb.size(), 1);
      if (qb.size() > 0) chk("b_write_addr", qb[0], 1283);

      // parameter sweep: 8 boids, size 3
      nc = 0;
      fs_c = 1'b1;
      t0 = cyc;
      tick();
      fs_c = 1'b0;
      off = -1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (done_c) begin
            off = cyc - t0;
            break;
         end
      end
      chk("c_done_at_82", off, 82);
      tick();
      chk("c_write_count", nc, 72);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
